// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared constants for the 8-bit CPU control path: opcode values, ALU select
// codes and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int OPW   = 8;
    localparam int CNT_W = 16;

    localparam int OP_LOADI = 0;
    localparam int OP_MOV   = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_J     = 6;
    localparam int OP_BEQ   = 7;
    localparam int OP_LWD   = 8;
    localparam int OP_LWI   = 9;
    localparam int OP_SWD   = 10;
    localparam int OP_SWI   = 11;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
// Purely combinational opcode classification used by the sequencer.
// Ports:
//   opcode_i     in  OPW  latched opcode
//   alu_sel_o    out 3    ALU function for EXEC
//   neg_o        out 1    two's-complement second operand (sub, beq)
//   imm_o        out 1    immediate second operand
//   is_mem_o     out 1    instruction needs the MEM state
//   is_load_o    out 1    memory read (else write) when is_mem_o
//   reg_wr_o     out 1    writes the register file in WB
//   is_branch_o  out 1    conditional branch (beq)
//   is_jump_o    out 1    unconditional jump
//   illegal_o    out 1    opcode outside the defined set
// -----------------------------------------------------------------------------
module opcode_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = cpu_ctrl_pkg::OPW
) (
    input  logic [OPW-1:0] opcode_i,
    output logic [2:0]     alu_sel_o,
    output logic           neg_o,
    output logic           imm_o,
    output logic           is_mem_o,
    output logic           is_load_o,
    output logic           reg_wr_o,
    output logic           is_branch_o,
    output logic           is_jump_o,
    output logic           illegal_o
);

    always_comb begin
        alu_sel_o   = ALU_FWD;
        neg_o       = 1'b0;
        imm_o       = 1'b0;
        is_mem_o    = 1'b0;
        is_load_o   = 1'b0;
        reg_wr_o    = 1'b0;
        is_branch_o = 1'b0;
        is_jump_o   = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OPW'(OP_LOADI): begin
                imm_o    = 1'b1;
                reg_wr_o = 1'b1;
            end
            OPW'(OP_MOV): begin
                reg_wr_o = 1'b1;
            end
            OPW'(OP_ADD): begin
                alu_sel_o = ALU_ADD;
                reg_wr_o  = 1'b1;
            end
            OPW'(OP_SUB): begin
                alu_sel_o = ALU_ADD;
                neg_o     = 1'b1;
                reg_wr_o  = 1'b1;
            end
            OPW'(OP_AND): begin
                alu_sel_o = ALU_AND;
                reg_wr_o  = 1'b1;
            end
            OPW'(OP_OR): begin
                alu_sel_o = ALU_OR;
                reg_wr_o  = 1'b1;
            end
            OPW'(OP_J): begin
                is_jump_o = 1'b1;
            end
            // beq compares by subtracting; the ALU zero flag decides the branch
            OPW'(OP_BEQ): begin
                alu_sel_o   = ALU_ADD;
                neg_o       = 1'b1;
                is_branch_o = 1'b1;
            end
            OPW'(OP_LWD): begin
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
                reg_wr_o  = 1'b1;
            end
            OPW'(OP_LWI): begin
                imm_o     = 1'b1;
                is_mem_o  = 1'b1;
                is_load_o = 1'b1;
                reg_wr_o  = 1'b1;
            end
            OPW'(OP_SWD): begin
                is_mem_o = 1'b1;
            end
            OPW'(OP_SWI): begin
                imm_o    = 1'b1;
                is_mem_o = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit CPU datapath.
// Drives every datapath strobe, stalls on memory busywait, traps illegal
// opcodes and counts retired instructions.
//
//   state  | meaning
//   FETCH  | request instruction; load IR when memory is ready
//   DECODE | classify opcode; illegal opcodes trap to HALT
//   EXEC   | drive ALU controls, capture ALU zero flag
//   MEM    | data memory read/write until busywait clears
//   WB     | register write-back, PC update, retire
//   HALT   | trapped; only RESET leaves
//
// Ports:
//   CLK, RESET (sync, active-high)
//   INSTRUCTION[31:0], IMEM_BUSYWAIT, DMEM_BUSYWAIT, ZERO   inputs
//   IMEM_READ, IR_LOAD, ALU_SEL[2:0], IS_NEGATIVE, IS_IMMEDIATE,
//   MEM_READ, MEM_WRITE, WB_SEL, REG_WRITE, PC_WRITE, PC_SEL,
//   HALTED, INSTR_COUNT[CNT_W-1:0]                          outputs
// -----------------------------------------------------------------------------
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW   = cpu_ctrl_pkg::OPW,
    parameter int CNT_W = cpu_ctrl_pkg::CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTRUCTION,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    input  logic             ZERO,
    output logic             IMEM_READ,
    output logic             IR_LOAD,
    output logic [2:0]       ALU_SEL,
    output logic             IS_NEGATIVE,
    output logic             IS_IMMEDIATE,
    output logic             MEM_READ,
    output logic             MEM_WRITE,
    output logic             WB_SEL,
    output logic             REG_WRITE,
    output logic             PC_WRITE,
    output logic             PC_SEL,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    state_t           state_q, state_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0] dec_alu_sel;
    logic       dec_neg;
    logic       dec_imm;
    logic       dec_is_mem;
    logic       dec_is_load;
    logic       dec_reg_wr;
    logic       dec_is_branch;
    logic       dec_is_jump;
    logic       dec_illegal;

    // Operand/address fields of the instruction belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^INSTRUCTION[31-OPW:0];

    opcode_decoder #(
        .OPW (OPW)
    ) u_decoder (
        .opcode_i    (opcode_q),
        .alu_sel_o   (dec_alu_sel),
        .neg_o       (dec_neg),
        .imm_o       (dec_imm),
        .is_mem_o    (dec_is_mem),
        .is_load_o   (dec_is_load),
        .reg_wr_o    (dec_reg_wr),
        .is_branch_o (dec_is_branch),
        .is_jump_o   (dec_is_jump),
        .illegal_o   (dec_illegal)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        zero_d   = zero_q;
        count_d  = count_q;
        case (state_q)
            ST_FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    opcode_d = INSTRUCTION[31 -: OPW];
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = dec_illegal ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                zero_d  = ZERO;
                state_d = dec_is_mem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (!DMEM_BUSYWAIT) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                count_d = count_q + CNT_W'(1);
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            zero_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            zero_q   <= zero_d;
            count_q  <= count_d;
        end
    end

    // Strobes are decoded from the registered state and forced low by RESET
    // so that memory requests drop in the very cycle reset is raised.
    always_comb begin
        IMEM_READ    = 1'b0;
        IR_LOAD      = 1'b0;
        ALU_SEL      = ALU_FWD;
        IS_NEGATIVE  = 1'b0;
        IS_IMMEDIATE = 1'b0;
        MEM_READ     = 1'b0;
        MEM_WRITE    = 1'b0;
        WB_SEL       = 1'b0;
        REG_WRITE    = 1'b0;
        PC_WRITE     = 1'b0;
        PC_SEL       = 1'b0;
        HALTED       = 1'b0;
        if (!RESET) begin
            case (state_q)
                ST_FETCH: begin
                    IMEM_READ = 1'b1;
                    IR_LOAD   = ~IMEM_BUSYWAIT;
                end
                ST_EXEC: begin
                    ALU_SEL      = dec_alu_sel;
                    IS_NEGATIVE  = dec_neg;
                    IS_IMMEDIATE = dec_imm;
                end
                ST_MEM: begin
                    MEM_READ  = dec_is_load;
                    MEM_WRITE = ~dec_is_load;
                end
                ST_WB: begin
                    PC_WRITE  = 1'b1;
                    REG_WRITE = dec_reg_wr;
                    WB_SEL    = dec_is_load;
                    PC_SEL    = dec_is_jump | (dec_is_branch & zero_q);
                end
                ST_HALT: begin
                    HALTED = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign INSTR_COUNT = RESET ? '0 : count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer. Two instances share stimulus: the
// default 16-bit counter and a 4-bit counter so that counter wrap is reached in
// a short run. Expected strobes come from an instruction-level timeline model.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INSTRUCTION = '0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        DMEM_BUSYWAIT = 1'b0;
    logic        ZERO = 1'b0;

    always #5 CLK = ~CLK;

    logic        a_imem_read, a_ir_load, a_neg, a_imm, a_mem_read, a_mem_write;
    logic        a_wb_sel, a_reg_write, a_pc_write, a_pc_sel, a_halted;
    logic [2:0]  a_alu_sel;
    logic [15:0] a_count;
    logic        b_imem_read, b_ir_load, b_neg, b_imm, b_mem_read, b_mem_write;
    logic        b_wb_sel, b_reg_write, b_pc_write, b_pc_sel, b_halted;
    logic [2:0]  b_alu_sel;
    logic [3:0]  b_count;

    control_sequencer #(.OPW(8), .CNT_W(16)) u_dut (
        .CLK (CLK), .RESET (RESET), .INSTRUCTION (INSTRUCTION),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT), .DMEM_BUSYWAIT (DMEM_BUSYWAIT), .ZERO (ZERO),
        .IMEM_READ (a_imem_read), .IR_LOAD (a_ir_load), .ALU_SEL (a_alu_sel),
        .IS_NEGATIVE (a_neg), .IS_IMMEDIATE (a_imm), .MEM_READ (a_mem_read),
        .MEM_WRITE (a_mem_write), .WB_SEL (a_wb_sel), .REG_WRITE (a_reg_write),
        .PC_WRITE (a_pc_write), .PC_SEL (a_pc_sel), .HALTED (a_halted),
        .INSTR_COUNT (a_count)
    );

    control_sequencer #(.OPW(8), .CNT_W(4)) u_dut_w (
        .CLK (CLK), .RESET (RESET), .INSTRUCTION (INSTRUCTION),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT), .DMEM_BUSYWAIT (DMEM_BUSYWAIT), .ZERO (ZERO),
        .IMEM_READ (b_imem_read), .IR_LOAD (b_ir_load), .ALU_SEL (b_alu_sel),
        .IS_NEGATIVE (b_neg), .IS_IMMEDIATE (b_imm), .MEM_READ (b_mem_read),
        .MEM_WRITE (b_mem_write), .WB_SEL (b_wb_sel), .REG_WRITE (b_reg_write),
        .PC_WRITE (b_pc_write), .PC_SEL (b_pc_sel), .HALTED (b_halted),
        .INSTR_COUNT (b_count)
    );

    // Strobe bit map: [0] IMEM_READ [1] IR_LOAD [4:2] ALU_SEL [5] IS_NEGATIVE
    // [6] IS_IMMEDIATE [7] MEM_READ [8] MEM_WRITE [9] WB_SEL [10] REG_WRITE
    // [11] PC_WRITE [12] PC_SEL [13] HALTED
    logic [13:0] a_strb, b_strb;
    assign a_strb = {a_halted, a_pc_sel, a_pc_write, a_reg_write, a_wb_sel, a_mem_write,
                     a_mem_read, a_imm, a_neg, a_alu_sel, a_ir_load, a_imem_read};
    assign b_strb = {b_halted, b_pc_sel, b_pc_write, b_reg_write, b_wb_sel, b_mem_write,
                     b_mem_read, b_imm, b_neg, b_alu_sel, b_ir_load, b_imem_read};

    typedef logic [47:0] vec_t;
    vec_t obs_q[$];
    vec_t exp_q[$];
    int   cnt = 0;
    int   vecs = 0;
    int   misses = 0;

    function automatic logic [2:0] alu_code(input logic [7:0] op);
        case (op)
            8'd2, 8'd3, 8'd7: return 3'b001;
            8'd4:             return 3'b010;
            8'd5:             return 3'b011;
            default:          return 3'b000;
        endcase
    endfunction

    task automatic sample(input logic [13:0] e, input int ec);
        obs_q.push_back({b_strb, b_count, a_count, a_strb});
        exp_q.push_back({e, 4'(ec), 16'(ec), e});
    endtask

    task automatic randomize_inputs();
        INSTRUCTION   = $urandom;
        IMEM_BUSYWAIT = 1'($urandom);
        DMEM_BUSYWAIT = 1'($urandom);
        ZERO          = 1'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        randomize_inputs();
        #1 sample('0, 0);
        cnt = 0;
    endtask

    // One instruction timeline: iw fetch stall cycles, dw data stall cycles.
    // Reset is raised at cycle abort_at (if reached) and the instruction ends.
    task automatic run_instr(input logic [7:0] op, input int iw, input int dw,
                             input bit z, input int abort_at);
        bit          legal, mem, load, wb;
        int          total, mem_end;
        logic [13:0] e;
        legal   = (op <= 8'd11);
        mem     = legal && (op >= 8'd8);
        load    = (op == 8'd8) || (op == 8'd9);
        mem_end = iw + 3 + dw;
        if (!legal)   total = iw + 6;
        else if (mem) total = mem_end + 2;
        else          total = iw + 4;
        for (int c = 0; c < total; c++) begin
            @(negedge CLK);
            RESET = (c == abort_at);
            randomize_inputs();
            e  = '0;
            wb = 1'b0;
            if (c <= iw) begin
                IMEM_BUSYWAIT = (c < iw);
                e[0] = 1'b1;
                if (c == iw) begin
                    INSTRUCTION[31:24] = op;
                    e[1] = 1'b1;
                end
            end else if (c == iw + 1) begin
                e = '0;
            end else if (!legal) begin
                e[13] = 1'b1;
            end else if (c == iw + 2) begin
                ZERO   = z;
                e[4:2] = alu_code(op);
                e[5]   = (op == 8'd3) || (op == 8'd7);
                e[6]   = (op == 8'd0) || (op == 8'd9) || (op == 8'd11);
            end else if (mem && c <= mem_end) begin
                DMEM_BUSYWAIT = (c < mem_end);
                e[7] = load;
                e[8] = !load;
            end else begin
                wb    = 1'b1;
                e[11] = 1'b1;
                e[10] = (op <= 8'd5) || load;
                e[9]  = load;
                e[12] = (op == 8'd6) || ((op == 8'd7) && z);
            end
            if (RESET) begin
                #1 sample('0, 0);
                cnt = 0;
                return;
            end
            #1 sample(e, cnt);
            if (wb) cnt++;
        end
    endtask

    task automatic test_reset();
        obs_q.delete(); exp_q.delete();
        apply_reset(); apply_reset(); apply_reset();
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL reset[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_add();
        obs_q.delete(); exp_q.delete();
        run_instr(8'd2, 0, 0, 1'($urandom), -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL add[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vecs++;
        if (obs_q[0][1] !== 1'b1 || obs_q[2][4:2] !== 3'b001 || obs_q[3][11:10] !== 2'b11) begin
            misses++;
            $display("FAIL add_timing: got irl=%b alu=%b wb=%b, want 1 001 11",
                     obs_q[0][1], obs_q[2][4:2], obs_q[3][11:10]);
        end
    endtask

    task automatic test_imem_wait();
        int n_rd, n_ir;
        obs_q.delete(); exp_q.delete();
        run_instr(8'($urandom_range(0, 5)), 3, 0, 1'($urandom), -1);
        n_rd = 0; n_ir = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_rd += int'(obs_q[i][0]);
            n_ir += int'(obs_q[i][1]);
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL imem_wait[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vecs++;
        if (n_rd != 4 || n_ir != 1 || obs_q[6][11] !== 1'b1) begin
            misses++;
            $display("FAIL imem_wait_counts: got rd=%0d ir=%0d pcw7=%b, want 4 1 1",
                     n_rd, n_ir, obs_q[6][11]);
        end
    endtask

    task automatic test_branch();
        obs_q.delete(); exp_q.delete();
        run_instr(8'd7, 0, 0, 1'b1, -1);
        run_instr(8'd7, 0, 0, 1'b0, -1);
        run_instr(8'd6, 1, 0, 1'($urandom), -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL branch[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vecs++;
        if (obs_q[3][12] !== 1'b1 || obs_q[7][12] !== 1'b0 || obs_q[12][12:10] !== 3'b110) begin
            misses++;
            $display("FAIL branch_pcsel: got beq1=%b beq0=%b j=%b, want 1 0 110",
                     obs_q[3][12], obs_q[7][12], obs_q[12][12:10]);
        end
    endtask

    task automatic test_mem();
        int n_mr;
        obs_q.delete(); exp_q.delete();
        run_instr(8'd8, 0, 2, 1'($urandom), -1);
        run_instr(8'd10, 0, 0, 1'($urandom), -1);
        run_instr(8'd9, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1);
        run_instr(8'd11, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), -1);
        n_mr = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (i < 7) n_mr += int'(obs_q[i][7]);
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL mem[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vecs++;
        if (n_mr != 3 || obs_q[6][10:9] !== 2'b11 || obs_q[10][8:7] !== 2'b10
            || obs_q[11][10] !== 1'b0) begin
            misses++;
            $display("FAIL mem_strobes: got mr=%0d lwd_wb=%b swd_mem=%b swd_rw=%b, want 3 11 10 0",
                     n_mr, obs_q[6][10:9], obs_q[10][8:7], obs_q[11][10]);
        end
    endtask

    task automatic test_halt();
        obs_q.delete(); exp_q.delete();
        run_instr(8'hFF, 0, 0, 1'b0, -1);
        apply_reset();
        run_instr(8'd2, 0, 0, 1'b0, -1);
        run_instr(8'($urandom_range(12, 254)), $urandom_range(0, 2), 0, 1'b0, -1);
        apply_reset();
        run_instr(8'd1, 0, 0, 1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL halt[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_mem_reset();
        obs_q.delete(); exp_q.delete();
        run_instr(8'd2, 0, 0, 1'b0, -1);
        run_instr(8'd10, 0, 5, 1'b0, 4);
        run_instr(8'd2, 0, 0, 1'b0, -1);
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL mid_mem_reset[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vecs++;
        if (obs_q[7][8] !== 1'b1 || obs_q[8][8] !== 1'b0 || obs_q[9][0] !== 1'b1) begin
            misses++;
            $display("FAIL mid_mem_reset_edges: got mw=%b%b fetch=%b, want 10 1",
                     obs_q[7][8], obs_q[8][8], obs_q[9][0]);
        end
    endtask

    task automatic test_wrap();
        obs_q.delete(); exp_q.delete();
        apply_reset();
        for (int k = 0; k < 16; k++) run_instr(8'($urandom_range(0, 7)), 0, 0, 1'($urandom), -1);
        @(negedge CLK);
        RESET = 1'b0;
        IMEM_BUSYWAIT = 1'b1;
        #1;
        vecs++;
        if (a_count !== 16'(cnt) || b_count !== 4'(cnt)) begin
            misses++;
            $display("FAIL wrap: got %h/%h, want %h/%h", a_count, b_count, 16'(cnt), 4'(cnt));
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL wrap[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            op = 8'($urandom_range(0, 11));
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), -1);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_q[i]) begin
                misses++;
                $display("FAIL back_to_back[%0d]: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imem_wait();
        test_branch();
        test_mem();
        test_halt();
        test_mid_mem_reset();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule
